seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Parametrised time-multiplexed 7-segment scan driver; next generation of the 4-digit switch display driver.
//  Drives NUM_DIGITS hex digits with per-digit enable, decimal points, leading-zero blanking and PWM brightness.
//  Inputs are shadowed once per frame, so a display never shows a mix of old and new values.
//  Sits between the datapath (hex value source) and the board's an/seg pins.
// PARAMETERS
//  NUM_DIGITS   4     digits driven, 1..8
//  REFRESH_DIV  4096  clocks per digit slot; power of two, >= 2**BRIGHT_W
//  BRIGHT_W     3     brightness code width; 2**BRIGHT_W duty levels
//  ACTIVE_LOW   1     1: an/seg asserted low (common-anode board); 0: asserted high
// PORTS
//  clk       in   1              system clock
//  rst_n     in   1              async active-low reset
//  data      in   4*NUM_DIGITS   hex nibbles; digit i = data[4i+3:4i], digit 0 rightmost
//  dp        in   NUM_DIGITS     decimal point per digit
//  digit_en  in   NUM_DIGITS     1 = digit shown, 0 = anode held off
//  blank_lz  in   1              leading-zero blanking enable
//  bright    in   BRIGHT_W       duty code; all-ones = full on
//  an        out  NUM_DIGITS     anode selects, one-hot when on
//  seg       out  8              seg[0..6] = a..g, seg[7] = dp
//  frame_tick out 1              1-clk pulse in the cycle the shadow registers load
// BEHAVIOUR
//  Reset (async, immediate): prescaler=0, idx=0, shadows=0, an=all-off, seg=all-off, frame_tick=0, load_pend=1.
//   "off" = 1 when ACTIVE_LOW=1, 0 otherwise.
//  Prescaler counts 0..REFRESH_DIV-1 and wraps. At terminal count idx advances 0..NUM_DIGITS-1, wrapping to 0.
//  Frame load happens on the first clock after reset release (load_pend) and whenever terminal count occurs with idx=NUM_DIGITS-1.
//   On a frame load, data/dp/digit_en/blank_lz are copied to the shadows and frame_tick=1 for that cycle.
//   bright is not shadowed; it is sampled every clock.
//  Decode uses the shadows only. Digit k is:
//   blanked (anode off) if digit_en[k]=0;
//   blanked if blank_lz=1, k!=0, and nibbles k..NUM_DIGITS-1 are all 0.
//   Digit 0 is never LZ-blanked.
//  PWM: digit on when prescaler[MSB -: BRIGHT_W] <= bright, giving duty (bright+1)/2**BRIGHT_W.
//  Hex map (active-high g..a): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
//   seg[7] = shadow dp[idx].
//   Whole byte inverted when ACTIVE_LOW=1.
//  When the digit is off or blanked: an=all-off and seg=all-off (no ghosting).
//  an/seg are registered, one clock of latency from the prescaler/idx state. Only one anode is ever on.
//  An input change mid-frame takes effect at the next frame_tick only; a frame lasts NUM_DIGITS*REFRESH_DIV clocks.
//  Reset asserted mid-frame: outputs go off in the same timestep; the scan restarts at digit 0 after release.
// STRUCTURE
//  Package seg7_pkg holds:
//   SEG_HEX[16] localparam table; SEG_OFF constant;
//   function hex_to_seg(nibble) -> 7b active-high.
//  One sub-module, seg7_hex_decode: combinational nibble+dp -> 8b pattern with ACTIVE_LOW inversion.
//  Top level holds the prescaler, digit index, shadows, LZ mask, PWM compare and output registers.
//  Elaboration check: NUM_DIGITS in 1..8; REFRESH_DIV power of two and >= 2**BRIGHT_W.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=16, BRIGHT_W=2, ACTIVE_LOW=1)
//  1 rst_n=0 -> an=4'hF, seg=8'hFF, frame_tick=0.
//    Release -> frame_tick=1 exactly 1 clk later.
//  2 data=16'h5555, digit_en=4'hF, bright=3, dp=0 -> an=E,D,B,7, each for 16 clks; seg=8'h92; frame_tick every 64 clks.
//  3 data=16'h9999 (seg=8'h90), then data=16'h1234 mid-frame -> 9s persist until frame_tick.
//    Then digit0 seg=8'h99, digit3 seg=8'hF9.
//  4 data=16'h0070, blank_lz=1, dp=4'b0001:
//    digits 3,2 -> an off, seg=FF;
//    digit1 -> seg=8'hF8;
//    digit0 -> seg=8'h40.
//  5 bright=0 -> active anode low for 4 of 16 clks per slot (prescaler 0..3).
//    bright=1 -> 8 of 16.
//  6 Async rst_n pulse at idx=2, prescaler=7 -> an=4'hF, seg=8'hFF in the same timestep.
//    After release, the scan restarts at an=E; the shadows reload.
//  Checker: one-hot-or-off on an every clock; an/seg match a reference model with a 1-clk lag.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan driver.
// Patterns here are active-high (g..a in bits 6..0); polarity is applied at the decoder.
package seg7_pkg;

   localparam int unsigned SEG_W = 8;

   localparam logic [6:0] SEG_HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // All segments and the decimal point dark, active-high sense.
   localparam logic [SEG_W-1:0] SEG_OFF = 8'h00;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      return SEG_HEX[nibble];
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble + decimal point to segment byte, with board polarity applied.
// A blanked digit produces the all-off pattern so a dark slot never ghosts.
module seg7_hex_decode
   import seg7_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0]       nibble_i,
   input  logic             dp_i,
   input  logic             blank_i,
   output logic [SEG_W-1:0] seg_o
);

   logic [SEG_W-1:0] pattern;

   always_comb begin
      pattern = blank_i ? SEG_OFF : {dp_i, hex_to_seg(nibble_i)};
      seg_o   = pattern ^ {SEG_W{ACTIVE_LOW}};
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver: prescaler, digit scan, per-frame input shadowing,
// leading-zero blanking and PWM brightness, with registered anode/segment outputs.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 4096,
   parameter int unsigned BRIGHT_W    = 3,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    blank_lz,
   input  logic [BRIGHT_W-1:0]     bright,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [SEG_W-1:0]        seg,
   output logic                    frame_tick
);

   localparam int unsigned PW = $clog2(REFRESH_DIV);
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [PW-1:0]         PRE_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};
   localparam logic [SEG_W-1:0]      SEG_DARK = {SEG_W{ACTIVE_LOW}};

   if ((NUM_DIGITS < 1) || (NUM_DIGITS > 8)) begin : g_chk_digits
      $error("seg7_scan_driver: NUM_DIGITS must be in 1..8");
   end
   if ((REFRESH_DIV & (REFRESH_DIV - 1)) != 0) begin : g_chk_pow2
      $error("seg7_scan_driver: REFRESH_DIV must be a power of two");
   end
   if (REFRESH_DIV < (2 ** BRIGHT_W)) begin : g_chk_bright
      $error("seg7_scan_driver: REFRESH_DIV must be >= 2**BRIGHT_W");
   end

   logic [PW-1:0]           prescaler_q, prescaler_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic                    load_pend_q, load_pend_d;
   logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d;
   logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
   logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
   logic                    sh_lz_q, sh_lz_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [SEG_W-1:0]        seg_q, seg_d;
   logic                    frame_tick_q, frame_tick_d;

   logic                    tc;
   logic                    frame_load;
   logic                    upper_zero;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_en;
   logic                    cur_blank;
   logic                    duty_on;
   logic                    digit_on;
   logic [NUM_DIGITS-1:0]   onehot;

   // Scan timing and frame shadow loading.
   always_comb begin
      tc          = (prescaler_q == PRE_LAST);
      frame_load  = load_pend_q | (tc & (idx_q == IDX_LAST));
      prescaler_d = tc ? '0 : prescaler_q + PW'(1);
      idx_d       = idx_q;
      if (tc) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end
      load_pend_d  = 1'b0;
      sh_data_d    = sh_data_q;
      sh_dp_d      = sh_dp_q;
      sh_en_d      = sh_en_q;
      sh_lz_d      = sh_lz_q;
      if (frame_load) begin
         sh_data_d = data;
         sh_dp_d   = dp;
         sh_en_d   = digit_en;
         sh_lz_d   = blank_lz;
      end
      frame_tick_d = frame_load;
   end

   // Walk from the most significant digit down; a digit is a leading zero while every
   // nibble at or above it is zero. Digit 0 always shows.
   always_comb begin
      upper_zero = 1'b1;
      lz_mask    = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         upper_zero = upper_zero & (sh_data_q[4*k +: 4] == 4'h0);
         if (k != 0) begin
            lz_mask[k] = sh_lz_q & upper_zero;
         end
      end
   end

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_en    = 1'b0;
      cur_blank = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            cur_nib   = sh_data_q[4*k +: 4];
            cur_dp    = sh_dp_q[k];
            cur_en    = sh_en_q[k];
            cur_blank = lz_mask[k];
         end
      end
   end

   // PWM: compare the top prescaler bits against the live brightness code.
   always_comb begin
      duty_on  = (prescaler_q[PW-1 -: BRIGHT_W] <= bright);
      digit_on = cur_en & ~cur_blank & duty_on;
      onehot   = NUM_DIGITS'(1) << idx_q;
      an_d     = digit_on ? (onehot ^ AN_OFF) : AN_OFF;
   end

   seg7_hex_decode #(
      .ACTIVE_LOW (ACTIVE_LOW)
   ) u_decode (
      .nibble_i (cur_nib),
      .dp_i     (cur_dp),
      .blank_i  (~digit_on),
      .seg_o    (seg_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler_q  <= '0;
         idx_q        <= '0;
         load_pend_q  <= 1'b1;
         sh_data_q    <= '0;
         sh_dp_q      <= '0;
         sh_en_q      <= '0;
         sh_lz_q      <= 1'b0;
         an_q         <= AN_OFF;
         seg_q        <= SEG_DARK;
         frame_tick_q <= 1'b0;
      end else begin
         prescaler_q  <= prescaler_d;
         idx_q        <= idx_d;
         load_pend_q  <= load_pend_d;
         sh_data_q    <= sh_data_d;
         sh_dp_q      <= sh_dp_d;
         sh_en_q      <= sh_en_d;
         sh_lz_q      <= sh_lz_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_tick = frame_tick_q;

endmodule
